// File: rtl/fpu_pkg.sv
// Shared types for the floating-point divider issue/result path.
package fpu_pkg;

    localparam int TAG_W = 5;

    // One buffered divider result, tagged with its destination and requester.
    typedef struct packed {
        logic [31:0]      y;
        logic             ovf;
        logic [TAG_W-1:0] tag;
        logic             src;
    } res_entry_t;

    // One slot of the shadow pipe that mirrors the divider's in-flight ops.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             src;
    } shadow_entry_t;

endpackage

// File: rtl/fdiv_sched_res_fifo.sv
// Synchronous result FIFO: registered head, no bypass, zeroed storage on reset.
module res_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; storage is cleared so an empty head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/fdiv_sched.sv
// Issue controller and result buffer for the shared fixed-latency divider.
// Two requesters are round-robin arbitrated; a shadow pipe tracks tags of
// in-flight ops and a credit counter keeps the non-stallable divider from
// ever overrunning the result FIFO.
module fdiv_sched
    import fpu_pkg::*;
#(
    parameter int LATENCY    = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = fpu_pkg::TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_x1,
    input  logic [31:0]      req0_x2,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_x1,
    input  logic [31:0]      req1_x2,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      div_x1,
    output logic [31:0]      div_x2,
    input  logic [31:0]      div_y,
    input  logic             div_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_y,
    output logic             res_ovf,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_src,
    output logic             busy
);

    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W  = $bits(res_entry_t);

    logic [CRED_W-1:0] cred_q, cred_d;
    logic              rr_q, rr_d;
    logic [31:0]       div_x1_q, div_x1_d;
    logic [31:0]       div_x2_q, div_x2_d;
    shadow_entry_t     shadow_q [LATENCY];
    shadow_entry_t     shadow_d [LATENCY];

    logic              winner;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [CRED_W-1:0] fifo_count;
    res_entry_t        push_entry;
    res_entry_t        head_entry;
    logic [ENT_W-1:0]  head_bits;

    // Round-robin winner; a lone valid requester wins regardless of rr.
    always_comb begin
        if (req0_valid && req1_valid) begin
            winner = rr_q;
        end else if (req1_valid) begin
            winner = 1'b1;
        end else if (req0_valid) begin
            winner = 1'b0;
        end else begin
            winner = rr_q;
        end
    end

    assign req0_ready = (cred_q != '0) && !rst && !winner;
    assign req1_ready = (cred_q != '0) && !rst &&  winner;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Issue path: operand registers, rr update and shadow-pipe shift.
    always_comb begin
        rr_d        = rr_q;
        div_x1_d    = div_x1_q;
        div_x2_d    = div_x2_q;
        shadow_d[0] = '0;
        if (accept) begin
            rr_d              = ~winner;
            div_x1_d          = winner ? req1_x1 : req0_x1;
            div_x2_d          = winner ? req1_x2 : req0_x2;
            shadow_d[0].valid = 1'b1;
            shadow_d[0].tag   = winner ? req1_tag : req0_tag;
            shadow_d[0].src   = winner;
        end
        for (int unsigned i = 1; i < LATENCY; i++) begin
            shadow_d[i] = shadow_q[i-1];
        end
    end

    // Completion capture from the divider and FIFO pop handshake.
    always_comb begin
        push           = shadow_q[LATENCY-1].valid;
        push_entry.y   = div_y;
        push_entry.ovf = div_ovf;
        push_entry.tag = shadow_q[LATENCY-1].tag;
        push_entry.src = shadow_q[LATENCY-1].src;
        pop            = res_ready && (fifo_count != '0);
    end

    // Credits: one per free FIFO slot not already promised to an in-flight op.
    always_comb begin
        case ({accept, pop})
            2'b10:   cred_d = cred_q - 1'b1;
            2'b01:   cred_d = cred_q + 1'b1;
            default: cred_d = cred_q;
        endcase
    end

    // State registers; divider internals are not ours, so clearing the
    // shadow valids is what discards any results still inside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cred_q   <= CRED_W'(FIFO_DEPTH);
            rr_q     <= 1'b0;
            div_x1_q <= '0;
            div_x2_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            cred_q   <= cred_d;
            rr_q     <= rr_d;
            div_x1_q <= div_x1_d;
            div_x2_q <= div_x2_d;
            shadow_q <= shadow_d;
        end
    end

    res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (push_entry),
        .pop     (pop),
        .rd_data (head_bits),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head_entry = head_bits;
    assign div_x1     = div_x1_q;
    assign div_x2     = div_x2_q;
    assign res_valid  = !fifo_empty;
    assign res_y      = head_entry.y;
    assign res_ovf    = head_entry.ovf;
    assign res_tag    = head_entry.tag;
    assign res_src    = head_entry.src;
    assign busy       = (cred_q != CRED_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_fdiv_sched.sv
// Directed bench for fdiv_sched with a behavioural fixed-latency divider.
module tb_fdiv_sched;

    localparam int LAT   = 5;
    localparam int DEPTH = 8;
    localparam int TW    = 5;

    typedef struct {
        logic          src;
        logic [31:0]   x1;
        logic [31:0]   x2;
        logic [TW-1:0] tag;
        logic [31:0]   exp_y;
        logic          exp_ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [31:0]   req0_x1, req0_x2, req1_x1, req1_x2;
    logic [TW-1:0] req0_tag, req1_tag;
    logic [31:0]   div_x1, div_x2, div_y;
    logic          div_ovf;
    logic          res_valid, res_ready;
    logic [31:0]   res_y;
    logic          res_ovf;
    logic [TW-1:0] res_tag;
    logic          res_src;
    logic          busy;

    int            n_vec = 0;
    int            n_err = 0;
    logic [38:0]   exp_q [$];
    logic [38:0]   mon_e;
    logic [32:0]   dpipe [0:LAT-2];

    fdiv_sched #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x1(req0_x1),
        .req0_x2(req0_x2), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x1(req1_x1),
        .req1_x2(req1_x2), .req1_tag(req1_tag),
        .div_x1(div_x1), .div_x2(div_x2), .div_y(div_y), .div_ovf(div_ovf),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_ovf(res_ovf), .res_tag(res_tag), .res_src(res_src), .busy(busy)
    );

    always #5 clk = ~clk;

    // Divider model, exact for divisors that are powers of two: {ovf, y}.
    function automatic logic [32:0] div_model(input logic [31:0] a, input logic [31:0] b);
        int e;
        if (b[22:0] != 23'd0 || b[30:23] == 8'd0) return 33'd0;
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (e >= 255) return {1'b1, a[31] ^ b[31], 8'hFF, 23'd0};
        return {1'b0, a[31] ^ b[31], e[7:0], a[22:0]};
    endfunction

    // Operands registered by the DUT reach div_y LAT edges after the accept edge.
    always @(posedge clk) begin
        dpipe[0] <= div_model(div_x1, div_x2);
        for (int i = 1; i < LAT - 1; i++) dpipe[i] <= dpipe[i-1];
    end
    assign {div_ovf, div_y} = dpipe[LAT-2];

    function automatic logic [38:0] ent(input vec_t v);
        return {v.exp_y, v.exp_ovf, v.tag, v.src};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Every popped result must match the next expected entry in order.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got y=%h tag=%0d src=%0d, required none",
                         res_y, res_tag, res_src);
            end else begin
                mon_e = exp_q.pop_front();
                if ({res_y, res_ovf, res_tag, res_src} !== mon_e) begin
                    n_err++;
                    $display("FAIL result: got y=%h ovf=%0d tag=%0d src=%0d, required y=%h ovf=%0d tag=%0d src=%0d",
                             res_y, res_ovf, res_tag, res_src,
                             mon_e[38:7], mon_e[6], mon_e[5:1], mon_e[0]);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic v, input vec_t op);
        if (idx == 0) begin
            req0_valid = v; req0_x1 = op.x1; req0_x2 = op.x2; req0_tag = op.tag;
        end else begin
            req1_valid = v; req1_x1 = op.x1; req1_x2 = op.x2; req1_tag = op.tag;
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || res_valid) && c < budget) begin
            next_cycle();
            c++;
        end
        chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t cont_tbl [6];
        vec_t ovf_tbl  [3];
        vec_t single, op, none;
        int   i0, i1, k;

        cont_tbl[0] = '{1'b0, 32'h41000000, 32'h40000000, 5'd1, 32'h40800000, 1'b0}; //  8/2
        cont_tbl[1] = '{1'b1, 32'h3F800000, 32'h40800000, 5'd2, 32'h3E800000, 1'b0}; //  1/4
        cont_tbl[2] = '{1'b0, 32'h41400000, 32'h40800000, 5'd3, 32'h40400000, 1'b0}; // 12/4
        cont_tbl[3] = '{1'b1, 32'h41200000, 32'h40000000, 5'd4, 32'h40A00000, 1'b0}; // 10/2
        cont_tbl[4] = '{1'b0, 32'hC0C00000, 32'h40000000, 5'd5, 32'hC0400000, 1'b0}; // -6/2
        cont_tbl[5] = '{1'b1, 32'h40400000, 32'h3F800000, 5'd6, 32'h40400000, 1'b0}; //  3/1
        ovf_tbl[0]  = '{1'b0, 32'h3F800000, 32'h3F000000, 5'd6, 32'h40000000, 1'b0}; // 1/0.5
        ovf_tbl[1]  = '{1'b0, 32'h7F000000, 32'h3F000000, 5'd7, 32'h7F800000, 1'b1}; // overflow
        ovf_tbl[2]  = '{1'b0, 32'h40A00000, 32'h40800000, 5'd8, 32'h3FA00000, 1'b0}; // 5/4
        single      = '{1'b0, 32'h40C00000, 32'h40000000, 5'd3, 32'h40400000, 1'b0}; // 6/2
        none        = '{1'b0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0};

        rst = 1'b1; res_ready = 1'b0;
        drive(0, 1'b0, none);
        drive(1, 1'b0, none);

        // Reset state, with a request pending so ready gating by rst is visible.
        repeat (2) next_cycle();
        drive(0, 1'b1, single);
        @(negedge clk);
        chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_x", {div_x1, div_x2}, 64'd0);
        chk("rst_res_fields", {res_y, res_ovf, res_tag, res_src}, 39'd0);
        chk("rst_cred", dut.cred_q, DEPTH);
        next_cycle();
        rst = 1'b0; res_ready = 1'b1;

        // Single op: result visible exactly LAT negedges after the accept edge.
        exp_q.push_back(ent(single));
        @(negedge clk);
        chk("single_ready", {req0_ready, req1_ready}, 2'b10);
        next_cycle();
        drive(0, 1'b0, none);
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("single_div_x", {div_x1, div_x2}, {32'h40C00000, 32'h40000000});
                chk("single_busy", busy, 1);
            end
            chk($sformatf("single_res_valid_c%0d", c), res_valid, (c == LAT) ? 1 : 0);
        end
        next_cycle();
        drain(20);

        // Contention: both requesters valid for 6 cycles, grants alternate from 0.
        pulse_reset();
        i0 = 0; i1 = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, 1'b1, cont_tbl[2 * ((i0 > 2) ? 2 : i0)]);
            drive(1, 1'b1, cont_tbl[2 * ((i1 > 2) ? 2 : i1) + 1]);
            @(negedge clk);
            chk($sformatf("cont_grant_c%0d", c), {req0_ready, req1_ready},
                (c % 2 == 0) ? 2'b10 : 2'b01);
            if (c % 2 == 0) begin exp_q.push_back(ent(cont_tbl[2 * i0])); i0++; end
            else            begin exp_q.push_back(ent(cont_tbl[2 * i1 + 1])); i1++; end
            next_cycle();
        end
        drive(0, 1'b0, none);
        drive(1, 1'b0, none);
        drain(30);

        // Back-pressure: exactly DEPTH accepts, then ready held low.
        res_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 14; c++) begin
            op = '{1'b0, {1'b0, 8'(100 + k), 23'(k)}, 32'h40000000, 5'(10 + k),
                   {1'b0, 8'(99 + k), 23'(k)}, 1'b0};
            drive(0, 1'b1, op);
            @(negedge clk);
            chk($sformatf("bp_ready_c%0d", c), req0_ready, (c < DEPTH) ? 1 : 0);
            if (c < DEPTH) begin exp_q.push_back(ent(op)); k++; end
            next_cycle();
        end
        chk("bp_cred_zero", dut.cred_q, 0);
        chk("bp_busy", busy, 1);
        chk("bp_full_valid", res_valid, 1);
        // One pop frees one credit; ready returns the cycle after the pop edge.
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_cycle_ready", req0_ready, 0);
        next_cycle();
        res_ready = 1'b0;
        @(negedge clk);
        chk("bp_reassert_ready", req0_ready, 1);
        exp_q.push_back(ent(op));
        next_cycle();
        @(negedge clk);
        chk("bp_refilled_ready", req0_ready, 0);
        next_cycle();
        drive(0, 1'b0, none);
        res_ready = 1'b1;
        drain(60);

        // Streaming: 20 back-to-back ops from req1, credits never exhausted.
        for (int c = 0; c < 20; c++) begin
            op = '{1'b1, {1'b0, 8'(100 + c), 23'(c * 3)}, 32'h40000000, 5'(c),
                   {1'b0, 8'(99 + c), 23'(c * 3)}, 1'b0};
            drive(1, 1'b1, op);
            @(negedge clk);
            chk($sformatf("stream_c%0d", c), {req0_ready, req1_ready, dut.cred_q != 0}, 3'b011);
            exp_q.push_back(ent(op));
            next_cycle();
        end
        drive(1, 1'b0, none);
        drain(30);

        // Overflow flag travels with tag 7 only.
        for (int c = 0; c < 3; c++) begin
            drive(0, 1'b1, ovf_tbl[c]);
            @(negedge clk);
            chk($sformatf("ovf_ready_c%0d", c), req0_ready, 1);
            exp_q.push_back(ent(ovf_tbl[c]));
            next_cycle();
        end
        drive(0, 1'b0, none);
        drain(30);

        // Reset mid-flight discards three ops still inside the divider.
        for (int c = 0; c < 3; c++) begin
            drive(0, 1'b1, cont_tbl[2 * c]);
            @(negedge clk);
            chk($sformatf("mid_ready_c%0d", c), req0_ready, 1);
            next_cycle();
        end
        drive(0, 1'b0, none);
        pulse_reset();
        for (int c = 0; c < 2 * LAT; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("mid_cred", dut.cred_q, DEPTH);
                chk("mid_busy", busy, 0);
            end
            chk($sformatf("mid_res_valid_c%0d", c), res_valid, 0);
            next_cycle();
        end
        drive(0, 1'b1, single);
        exp_q.push_back(ent(single));
        @(negedge clk);
        chk("post_reset_ready", req0_ready, 1);
        next_cycle();
        drive(0, 1'b0, none);
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
